// File: rtl/expr_eval.sv
// Single-digit '+'/'*' expression evaluator over an ASCII stream; '*' binds tighter than '+'.
// Define EXPR_OVF_EN to add the ovf output, flagging expressions whose arithmetic wrapped modulo 2^W.
module expr_eval #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic [W-1:0] result,
    output logic         res_valid,
    output logic         res_err,
`ifdef EXPR_OVF_EN
    output logic         ovf,
`endif
    output logic         syntax_ok
);

    typedef enum logic [2:0] {StInit, StNum, StOpAdd, StOpMul, StErr} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] sum_q, sum_d, prod_q, prod_d;
    logic [W-1:0] result_q, result_d;
    logic         res_valid_q, res_valid_d;
    logic         res_err_q, res_err_d;
    logic         emit_ok, emit_err;
    logic         is_digit, is_plus, is_mul, is_term;
    logic [W-1:0] dig;

    assign is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign is_plus  = (in == 8'h2b);
    assign is_mul   = (in == 8'h2a);
    assign is_term  = (in == 8'h3d);
    assign dig      = W'(in[3:0]);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= StInit;
            sum_q       <= '0;
            prod_q      <= '0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            prod_q      <= prod_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        prod_d   = prod_q;
        emit_ok  = 1'b0;
        emit_err = 1'b0;
        if (in_valid) begin
            case (state_q)
                StInit: begin
                    if (is_digit) begin
                        state_d = StNum;
                        prod_d  = dig;
                        sum_d   = '0;
                    end else if (is_term) begin
                        emit_err = 1'b1;
                    end else begin
                        state_d = StErr;
                    end
                end
                StOpAdd: begin
                    if (is_digit) begin
                        state_d = StNum;
                        prod_d  = dig;
                    end else if (is_term) begin
                        emit_err = 1'b1;
                    end else begin
                        state_d = StErr;
                    end
                end
                StOpMul: begin
                    if (is_digit) begin
                        state_d = StNum;
                        prod_d  = prod_q * dig;
                    end else if (is_term) begin
                        emit_err = 1'b1;
                    end else begin
                        state_d = StErr;
                    end
                end
                StNum: begin
                    if (is_plus) begin
                        state_d = StOpAdd;
                        sum_d   = sum_q + prod_q;
                        prod_d  = '0;
                    end else if (is_mul) begin
                        state_d = StOpMul;
                    end else if (is_term) begin
                        emit_ok = 1'b1;
                    end else begin
                        // A second digit in a row is a syntax error: numbers are single-digit.
                        state_d = StErr;
                    end
                end
                default: begin
                    if (is_term) emit_err = 1'b1;
                end
            endcase
            if (emit_ok || emit_err) begin
                state_d = StInit;
                sum_d   = '0;
                prod_d  = '0;
            end
        end
    end

    always_comb begin
        result_d    = result_q;
        res_err_d   = res_err_q;
        res_valid_d = emit_ok || emit_err;
        if (emit_ok) begin
            result_d  = sum_q + prod_q;
            res_err_d = 1'b0;
        end else if (emit_err) begin
            result_d  = '0;
            res_err_d = 1'b1;
        end
    end

    assign result    = result_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;
    assign syntax_ok = (state_q == StNum);

`ifdef EXPR_OVF_EN
    logic [W-1:0] add_sum;
    logic [W+3:0] mul_full;
    logic         add_carry, mul_ovf;
    logic         acc_q, acc_d, ovf_q, ovf_d;

    assign add_sum   = sum_q + prod_q;
    assign add_carry = (add_sum < sum_q);
    assign mul_full  = {4'b0000, prod_q} * {{W{1'b0}}, in[3:0]};
    assign mul_ovf   = |mul_full[W+3:W];

    // acc is the sticky wrap flag of the expression in progress; ovf is its emitted copy.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (emit_ok) begin
            ovf_d = acc_q | add_carry;
            acc_d = 1'b0;
        end else if (emit_err) begin
            ovf_d = 1'b0;
            acc_d = 1'b0;
        end else if (in_valid) begin
            if (state_q == StInit) begin
                acc_d = 1'b0;
            end else if ((state_q == StNum) && is_plus) begin
                acc_d = acc_q | add_carry;
            end else if ((state_q == StOpMul) && is_digit) begin
                acc_d = acc_q | mul_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_expr_eval.sv
// Randomized bench for expr_eval: each expression is buffered as text and evaluated at '='.
// Build with EXPR_OVF_EN defined to also check the ovf output.
module tb_expr_eval;
    localparam int unsigned W = 16;
    localparam longint M = 64'd1 << W;

    logic         clk = 1'b0;
    logic         clr_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_ch = 8'h00;
    logic [W-1:0] result;
    logic         res_valid, res_err, syntax_ok;
`ifdef EXPR_OVF_EN
    logic         ovf;
`endif

    expr_eval #(.W(W)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .in_valid (in_valid),
        .in       (in_ch),
        .result   (result),
        .res_valid(res_valid),
        .res_err  (res_err),
`ifdef EXPR_OVF_EN
        .ovf      (ovf),
`endif
        .syntax_ok(syntax_ok)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // Reference model: text of the expression in progress plus the last emitted outputs.
    byte unsigned expr_q[$];
    logic [W-1:0] exp_result = '0;
    logic         exp_valid = 1'b0;
    logic         exp_err = 1'b0;
    logic         exp_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_dig(input byte unsigned c);
        return (c >= "0") && (c <= "9");
    endfunction

    // Well-formed means: digit (op digit)* with op in {'+','*'}.
    function automatic bit complete();
        if (expr_q.size() == 0 || (expr_q.size() % 2) == 0) return 1'b0;
        for (int i = 0; i < expr_q.size(); i++) begin
            if (i % 2 == 0) begin
                if (!is_dig(expr_q[i])) return 1'b0;
            end else if (expr_q[i] != "+" && expr_q[i] != "*") begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic evaluate();
        longint s = 0;
        longint p = 0;
        bit     ov = 1'b0;
        if (!complete()) begin
            exp_result = '0;
            exp_err    = 1'b1;
            exp_ovf    = 1'b0;
            return;
        end
        p = longint'(expr_q[0] - "0");
        for (int i = 1; i < expr_q.size(); i += 2) begin
            longint d = longint'(expr_q[i+1] - "0");
            if (expr_q[i] == "+") begin
                s = s + p;
                if (s >= M) ov = 1'b1;
                s = s % M;
                p = d;
            end else begin
                p = p * d;
                if (p >= M) ov = 1'b1;
                p = p % M;
            end
        end
        s = s + p;
        if (s >= M) ov = 1'b1;
        exp_result = W'(s % M);
        exp_err    = 1'b0;
        exp_ovf    = ov;
    endtask

    task automatic model_step(input bit v, input byte unsigned c);
        exp_valid = 1'b0;
        if (v) begin
            if (c == "=") begin
                evaluate();
                exp_valid = 1'b1;
                expr_q.delete();
            end else begin
                expr_q.push_back(c);
            end
        end
    endtask

    task automatic model_reset();
        expr_q.delete();
        exp_result = '0;
        exp_valid  = 1'b0;
        exp_err    = 1'b0;
        exp_ovf    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (started && clr_n) begin
            check("res_valid", 32'(res_valid), 32'(exp_valid));
            check("result", 32'(result), 32'(exp_result));
            check("res_err", 32'(res_err), 32'(exp_err));
            check("syntax_ok", 32'(syntax_ok), 32'(complete()));
`ifdef EXPR_OVF_EN
            check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
        end
    end

    // Called at a falling edge; returns at the next falling edge with the model advanced.
    task automatic put(input bit v, input byte unsigned c);
        in_valid = v;
        in_ch    = c;
        @(posedge clk);
        model_step(v, c);
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) put(1'b1, s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 8'($urandom));
    endtask

    task automatic reset_mid();
        in_valid = 1'b0;
        #1 clr_n = 1'b0;
        model_reset();
        #1;
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_err", 32'(res_err), 32'd0);
        check("rst_syntax_ok", 32'(syntax_ok), 32'd0);
        #1 clr_n = 1'b1;
        @(posedge clk);
        model_step(1'b0, 8'h00);
        @(negedge clk);
    endtask

    function automatic byte unsigned rand_char();
        int unsigned r = $urandom_range(0, 99);
        if (r < 50) return byte'("0" + $urandom_range(0, 9));
        if (r < 70) return "+";
        if (r < 88) return "*";
        if (r < 92) return "=";
        return byte'($urandom);
    endfunction

    initial begin
        #1 clr_n = 1'b0;
        #1;
        check("init_result", 32'(result), 32'd0);
        check("init_valid", 32'(res_valid), 32'd0);
        check("init_err", 32'(res_err), 32'd0);
        check("init_syntax_ok", 32'(syntax_ok), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr_n   = 1'b1;
        started = 1'b1;

        send_str("3");
        check("t1_syntax_3", 32'(syntax_ok), 32'd1);
        send_str("+");
        check("t1_syntax_plus", 32'(syntax_ok), 32'd0);
        send_str("4*5=");
        check("t1_valid", 32'(res_valid), 32'd1);
        check("t1_result", 32'(result), 32'd23);
        check("t1_err", 32'(res_err), 32'd0);

        send_str("9*9*9*9*9=");
        check("t2a_result", 32'(result), 32'd59049);
`ifdef EXPR_OVF_EN
        check("t2a_ovf", 32'(ovf), 32'd0);
`endif
        send_str("9*9*9*9*9*9=");
        check("t2b_result", 32'(result), 32'd7153);
`ifdef EXPR_OVF_EN
        check("t2b_ovf", 32'(ovf), 32'd1);
`endif

        send_str("3+=");
        check("t3a_result", 32'(result), 32'd0);
        check("t3a_err", 32'(res_err), 32'd1);
        send_str("12=");
        check("t3b_err", 32'(res_err), 32'd1);
        send_str("7=");
        check("t3c_result", 32'(result), 32'd7);
        check("t3c_err", 32'(res_err), 32'd0);
        idle(1);
        check("t3_held_result", 32'(result), 32'd7);

        send_str("2*a5+1=");
        check("t4a_err", 32'(res_err), 32'd1);
        send_str("0*9+8=");
        check("t4b_result", 32'(result), 32'd8);
        check("t4b_err", 32'(res_err), 32'd0);

        send_str("5*");
        reset_mid();
        send_str("2=");
        check("t5_result", 32'(result), 32'd2);

        send_str("4+");
        idle(5);
        check("t6_syntax_idle", 32'(syntax_ok), 32'd0);
        send_str("6=");
        check("t6_result", 32'(result), 32'd10);

        for (int e = 0; e < 250; e++) begin
            int n = $urandom_range(0, 6);
            bit junk = ($urandom_range(0, 9) == 0);
            for (int k = 0; k <= 2 * n; k++) begin
                byte unsigned c;
                if (junk) c = rand_char();
                else if (k % 2 == 0) c = byte'("0" + $urandom_range(0, 9));
                else c = ($urandom_range(0, 1) == 0) ? "+" : "*";
                if ($urandom_range(0, 199) == 0) reset_mid();
                put(1'b1, c);
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
            end
            put(1'b1, "=");
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
